// File: rtl/stdout_uart_tx_if.sv
// Output-byte stream from the processor core into the stdout UART.
// The master drives the byte and its level strobe; the UART is the slave.
interface stdout_uart_tx_if;
    logic [7:0] stdout;
    logic       stdout_en;

    modport master (
        output stdout,
        output stdout_en
    );

    modport slave (
        input stdout,
        input stdout_en
    );
endinterface

// File: rtl/stdout_uart_tx.sv
// Buffered stdout UART transmitter: strobe-edge capture, byte FIFO, 8N1 serialiser.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
module stdout_uart_tx #(
    parameter int CLKS_PER_BIT    = 104,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    stdout_uart_tx_if.slave          up,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int NW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            par;
    logic            en_d;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [NW-1:0]   count;
    logic [NW-1:0]   count_nxt;
    logic [7:0]      mem [DEPTH];
    logic            push;
    logic            pop;
    logic            full;
    logic            wr;
    logic            baud_end;

    assign push     = up.stdout_en & ~en_d;
    assign full     = (count == FULL_CNT);
    assign pop      = (state == IDLE) & (count != '0);
    // When full, a same-cycle pop frees the slot the push lands in.
    assign wr       = push & (~full | pop);
    assign baud_end = (baud == BAUD_LAST);

    assign fifo_count = count;

    always_comb begin
        count_nxt = count;
        unique case ({wr, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[tail] <= up.stdout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_d     <= 1'b1;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            en_d  <= up.stdout_en;
            count <= count_nxt;
            if (wr)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !wr)
                overflow <= 1'b1;
        end
    end

    // tx is registered from the current state, so it trails state by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            busy <= (state != IDLE) | pop | (count_nxt != '0);
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= mem[head];
                        par   <= ^mem[head];
                        baud  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (baud_end) begin
                        baud  <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    tx <= par;
                    if (baud_end) begin
                        baud  <= '0;
                        state <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud  <= '0;
                        state <= IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx: frame-level reference model plus directed
// latency, burst, reset and random strobe traffic.
module tb_stdout_uart_tx;

    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * CPB;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           tx;
    logic           busy;
    logic           ovf;
    logic [DL2:0]   fcnt;

    stdout_uart_tx_if sif ();

    stdout_uart_tx #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (DL2)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .up         (sif),
        .tx         (tx),
        .busy       (busy),
        .overflow   (ovf),
        .fifo_count (fcnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of accepted bytes and the age of the current frame.
    logic [7:0]       q [$];
    bit               m_en_d = 1'b1;
    bit               m_ovf  = 1'b0;
    int               m_pos  = -1;
    logic [NBITS-1:0] m_frame = '1;

    function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef UART_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_en_d = 1'b1;
            m_ovf  = 1'b0;
            m_pos  = -1;
        end else begin
            bit pu, po, fu;
            fu = (q.size() == DEPTH);
            pu = sif.stdout_en && !m_en_d;
            po = (m_pos < 0 || m_pos >= FLEN) && q.size() != 0;
            if (po) begin
                m_frame = frame_of(q.pop_front());
                m_pos   = 0;
            end else if (m_pos >= FLEN) begin
                m_pos = -1;
            end else if (m_pos >= 0) begin
                m_pos++;
            end
            if (pu) begin
                if (!fu || po) q.push_back(sif.stdout);
                else           m_ovf = 1'b1;
            end
            m_en_d = sif.stdout_en;
        end
    end

    function automatic logic exp_tx();
        if (m_pos >= 1 && m_pos <= FLEN)
            return m_frame[(m_pos - 1) / CPB];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        check("tx", tx, exp_tx());
        check("fifo_count", fcnt, q.size());
        check("busy", busy, (q.size() != 0 || m_pos >= 0));
        check("overflow", ovf, m_ovf);
    end

    // Independent serial receiver sampling mid-bit.
    logic [7:0] rx_q [$];
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rb[b] = tx;
                end
                rx_q.push_back(rb);
                repeat (CPB * (NBITS - 9)) @(negedge clk);
            end
        end
    end

    int maxc;

    task automatic pulse(input logic [7:0] b, input int hold);
        @(negedge clk);
        sif.stdout    = b;
        sif.stdout_en = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (int'(fcnt) > maxc) maxc = int'(fcnt);
        end
        sif.stdout_en = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        repeat (2) @(negedge clk);
        while (busy && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check("drain", busy, 1'b0);
    endtask

    initial begin
        sif.stdout    = 8'h00;
        sif.stdout_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_cnt", fcnt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single byte latency
        pulse(8'h48, 1);
        check("lat_cnt", fcnt, 1);
        @(negedge clk);
        check("lat_tx1", tx, 1'b1);
        @(negedge clk);
        check("lat_tx0", tx, 1'b0);
        drain();
        check("single_cnt", fcnt, 0);

        // held strobe
        maxc = 0;
        pulse(8'h41, 10);
        drain();
        check("held_max", maxc, 1);

        // burst into a 4-deep FIFO
        rx_q.delete();
        for (int i = 0; i < 7; i++)
            pulse(8'h30 + 8'(i), 1);
        check("burst_ovf", ovf, 1'b1);
        drain();
        repeat (CPB * 2) @(negedge clk);
        check("rx_n", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            check("rx_byte", rx_q[i], 8'h30 + 8'(i));

        // reset during data bit 3 with bytes queued
        pulse(8'h5A, 1);
        pulse(8'h11, 1);
        pulse(8'h22, 1);
        begin
            int i;
            i = 0;
            while (!(m_pos - 1 >= 4 * CPB && m_pos - 1 < 5 * CPB)
                   && i < 200) begin
                @(negedge clk);
                i++;
            end
            check("bit3_wait", (i < 200), 1'b1);
        end
        #2 rst_n = 1'b0;
        #1 check("mid_rst_tx", tx, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_cnt", fcnt, 0);
        check("post_ovf", ovf, 1'b0);
        check("post_busy", busy, 1'b0);

        // strobe already high across reset release
        rst_n = 1'b0;
        sif.stdout    = 8'h99;
        sif.stdout_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("hi_rel_cnt", fcnt, 0);
        check("hi_rel_busy", busy, 1'b0);
        sif.stdout_en = 1'b0;
        @(negedge clk);
        sif.stdout_en = 1'b1;
        @(negedge clk);
        check("hi_rel_push", fcnt, 1);
        sif.stdout_en = 1'b0;
        drain();

        // random strobe traffic with occasional resets
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            sif.stdout = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                sif.stdout_en = ~sif.stdout_en;
            if (i % 800 == 799) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        sif.stdout_en = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
